// File: rtl/vtg_pkg.sv
// Shared timing defaults (336x240 arcade raster) and the sync-start clamp helper.
package vtg_pkg;

    localparam int unsigned H_ACTIVE_DEF     = 336;
    localparam int unsigned H_TOTAL_DEF      = 456;
    localparam int unsigned H_SYNC_START_DEF = 360;
    localparam int unsigned H_SYNC_LEN_DEF   = 24;
    localparam int unsigned V_ACTIVE_DEF     = 240;
    localparam int unsigned V_TOTAL_DEF      = 262;
    localparam int unsigned V_SYNC_START_DEF = 241;
    localparam int unsigned V_SYNC_LEN_DEF   = 3;
    localparam int unsigned CNT_W_DEF        = 10;
    localparam int unsigned OFFS_W_DEF       = 5;
    localparam int unsigned RGB_W_DEF        = 8;

    // Keeps an offset-shifted sync start inside blanking and the window inside the line.
    function automatic int sync_clamp(int pos, int lo, int hi);
        if (pos < lo) return lo;
        if (pos > hi) return hi;
        return pos;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel-side bundle between the game core / video chain and the raster timing generator.
interface video_timing_gen_if
    import vtg_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned OFFS_W = OFFS_W_DEF,
    parameter int unsigned RGB_W  = RGB_W_DEF
);
    logic                     ce_pix;
    logic signed [OFFS_W-1:0] hoffs;
    logic signed [OFFS_W-1:0] voffs;
    logic [RGB_W-1:0]         rgb_in;
    logic [CNT_W-1:0]         hpos;
    logic [CNT_W-1:0]         vpos;
    logic [RGB_W-1:0]         rgb_out;
    logic                     hblank;
    logic                     vblank;
    logic                     hsync_n;
    logic                     vsync_n;
    logic                     de;
    logic                     frame_start;

    modport master (
        output ce_pix, hoffs, voffs, rgb_in,
        input  hpos, vpos, rgb_out, hblank, vblank, hsync_n, vsync_n, de, frame_start
    );

    modport slave (
        input  ce_pix, hoffs, voffs, rgb_in,
        output hpos, vpos, rgb_out, hblank, vblank, hsync_n, vsync_n, de, frame_start
    );

endinterface

// File: rtl/vtg_axis.sv
// One raster axis: wrapping position counter with end flag, blank compare and sync window.
module vtg_axis
    import vtg_pkg::*;
#(
    parameter int unsigned TOTAL    = H_TOTAL_DEF,
    parameter int unsigned ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned SYNC_LEN = H_SYNC_LEN_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic [CNT_W-1:0] sync_start,
    output logic [CNT_W-1:0] cnt,
    output logic             at_end,
    output logic             blank,
    output logic             sync
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_x;
    logic [CNT_W:0]   start_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (adv) begin
            cnt_q <= at_end ? '0 : cnt_q + 1'b1;
        end
    end

    // One extra bit so start + length may reach 2**CNT_W without wrapping.
    assign cnt_x   = {1'b0, cnt_q};
    assign start_x = {1'b0, sync_start};

    assign cnt    = cnt_q;
    assign at_end = (cnt_q == CNT_W'(TOTAL - 1));
    assign blank  = (cnt_q >= CNT_W'(ACTIVE));
    assign sync   = (cnt_x >= start_x) && (cnt_x < start_x + (CNT_W + 1)'(SYNC_LEN));

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with frame-latched, clamped sync offsets.
// Define VTG_VOFFS_EN to enable the vertical sync offset (voffs); otherwise vsync is nominal.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
    parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
    parameter int unsigned H_SYNC_LEN   = H_SYNC_LEN_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
    parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
    parameter int unsigned V_SYNC_LEN   = V_SYNC_LEN_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned OFFS_W       = OFFS_W_DEF,
    parameter int unsigned RGB_W        = RGB_W_DEF
) (
    input logic               clk_sys,
    input logic               reset,
    video_timing_gen_if.slave bus
);

    if ((H_SYNC_START + H_SYNC_LEN > H_TOTAL) || (V_SYNC_START + V_SYNC_LEN > V_TOTAL) ||
        (H_ACTIVE >= H_TOTAL) || (V_ACTIVE >= V_TOTAL) ||
        (H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_cfg_err
        $error("video_timing_gen: inconsistent timing parameters");
    end

    logic signed [OFFS_W-1:0] hoffs_l;
    logic signed [OFFS_W-1:0] voffs_l;
    logic signed [CNT_W:0]    hs_raw;
    logic signed [CNT_W:0]    vs_raw;
    logic [CNT_W-1:0]         hs_b;
    logic [CNT_W-1:0]         vs_b;
    logic [CNT_W-1:0]         hcnt;
    logic [CNT_W-1:0]         vcnt;
    logic                     h_end, h_blank, h_sync;
    logic                     v_end, v_blank, v_sync;
    logic                     wrap;

    logic [RGB_W-1:0] rgb_out_q;
    logic             hblank_q, vblank_q, hsync_n_q, vsync_n_q, de_q, frame_start_q;

    assign wrap = bus.ce_pix & h_end & v_end;

    // Offsets widened with sign before the add so negative steps cannot wrap.
    assign hs_raw = signed'((CNT_W + 1)'(H_SYNC_START)) + ((CNT_W + 1)'(hoffs_l) <<< 1);
    assign vs_raw = signed'((CNT_W + 1)'(V_SYNC_START)) + (CNT_W + 1)'(voffs_l);
    assign hs_b   = CNT_W'(sync_clamp(int'(hs_raw), H_ACTIVE, H_TOTAL - H_SYNC_LEN));
    assign vs_b   = CNT_W'(sync_clamp(int'(vs_raw), V_ACTIVE, V_TOTAL - V_SYNC_LEN));

    vtg_axis #(
        .TOTAL    (H_TOTAL),
        .ACTIVE   (H_ACTIVE),
        .SYNC_LEN (H_SYNC_LEN),
        .CNT_W    (CNT_W)
    ) u_h_axis (
        .clk        (clk_sys),
        .rst        (reset),
        .adv        (bus.ce_pix),
        .sync_start (hs_b),
        .cnt        (hcnt),
        .at_end     (h_end),
        .blank      (h_blank),
        .sync       (h_sync)
    );

    vtg_axis #(
        .TOTAL    (V_TOTAL),
        .ACTIVE   (V_ACTIVE),
        .SYNC_LEN (V_SYNC_LEN),
        .CNT_W    (CNT_W)
    ) u_v_axis (
        .clk        (clk_sys),
        .rst        (reset),
        .adv        (bus.ce_pix & h_end),
        .sync_start (vs_b),
        .cnt        (vcnt),
        .at_end     (v_end),
        .blank      (v_blank),
        .sync       (v_sync)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hoffs_l <= '0;
        end else if (wrap) begin
            hoffs_l <= bus.hoffs;
        end
    end

`ifdef VTG_VOFFS_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            voffs_l <= '0;
        end else if (wrap) begin
            voffs_l <= bus.voffs;
        end
    end
`else
    logic unused_voffs;
    assign unused_voffs = ^bus.voffs;
    assign voffs_l      = '0;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rgb_out_q     <= '0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= wrap;
            if (bus.ce_pix) begin
                hblank_q  <= h_blank;
                vblank_q  <= v_blank;
                hsync_n_q <= ~h_sync;
                vsync_n_q <= ~v_sync;
                de_q      <= ~(h_blank | v_blank);
                rgb_out_q <= (h_blank | v_blank) ? '0 : bus.rgb_in;
            end
        end
    end

    assign bus.hpos        = hcnt;
    assign bus.vpos        = vcnt;
    assign bus.rgb_out     = rgb_out_q;
    assign bus.hblank      = hblank_q;
    assign bus.vblank      = vblank_q;
    assign bus.hsync_n     = hsync_n_q;
    assign bus.vsync_n     = vsync_n_q;
    assign bus.de          = de_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default horizontal timing, shortened 14-line frame.
module tb_video_timing_gen;

    localparam int HT     = 456;
    localparam int HA     = 336;
    localparam int VT     = 14;
    localparam int VA     = 8;
    localparam int VS_NOM = 9;
`ifdef VTG_VOFFS_EN
    localparam int VS_OFF = 11;
`else
    localparam int VS_OFF = 9;
`endif

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Per-line and per-frame statistics
    int hs_first, hs_len, de_cnt, vs_cnt, pos_bad, rgb_bad, hb_bad, fs_cnt, fs_last;
    int f_hs_bad, f_de, f_vs_first, f_vs_lines, f_vs_partial, f_fs, f_fs_last, f_bad, f_hb;

    video_timing_gen_if bus ();

    video_timing_gen #(
        .V_ACTIVE     (VA),
        .V_TOTAL      (VT),
        .V_SYNC_START (VS_NOM),
        .V_SYNC_LEN   (3)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ce_cycle(input logic [7:0] pix);
        @(negedge clk_sys);
        bus.ce_pix = 1'b1;
        bus.rgb_in = pix;
        @(negedge clk_sys);
        bus.ce_pix = 1'b0;
    endtask

    // Runs one full line starting at column 0 of the given line number.
    task automatic run_line(input int line);
        logic [7:0] pix;
        logic       act;
        int         col, exp_h, exp_v;
        hs_first = -1; hs_len = 0; de_cnt = 0; vs_cnt = 0; pos_bad = 0;
        rgb_bad = 0; hb_bad = 0; fs_cnt = 0; fs_last = 0;
        for (int k = 1; k <= HT; k++) begin
            pix = 8'((k * 7 + line) | 1);
            ce_cycle(pix);
            col = k - 1;
            act = (col < HA) && (line < VA);
            if (bus.hsync_n === 1'b0) begin
                if (hs_first < 0) hs_first = col;
                hs_len++;
                if (bus.hblank !== 1'b1) hb_bad++;
            end
            if (bus.de === 1'b1) de_cnt++;
            if (bus.vsync_n === 1'b0) vs_cnt++;
            if (bus.de !== act || bus.hblank !== (col >= HA) || bus.vblank !== (line >= VA) ||
                bus.rgb_out !== (act ? pix : 8'h00)) rgb_bad++;
            exp_h = k % HT;
            exp_v = (k == HT) ? (line + 1) % VT : line;
            if (bus.hpos !== 10'(exp_h) || bus.vpos !== 10'(exp_v)) pos_bad++;
            if (bus.frame_start === 1'b1) begin
                fs_cnt++;
                if (k == HT && line == VT - 1) fs_last = 1;
            end
        end
    endtask

    task automatic run_frame(input string name, input int hs_exp, input int vs_exp,
                             input int chg_line, input int chg_val);
        f_hs_bad = 0; f_de = 0; f_vs_first = -1; f_vs_lines = 0; f_vs_partial = 0;
        f_fs = 0; f_fs_last = 0; f_bad = 0; f_hb = 0;
        for (int l = 0; l < VT; l++) begin
            if (l == chg_line) bus.hoffs = 5'(chg_val);
            run_line(l);
            if (hs_first != hs_exp || hs_len != 24) f_hs_bad++;
            f_de += de_cnt;
            if (vs_cnt == HT) begin
                f_vs_lines++;
                if (f_vs_first < 0) f_vs_first = l;
            end else if (vs_cnt != 0) begin
                f_vs_partial++;
            end
            f_fs += fs_cnt;
            f_fs_last |= fs_last;
            f_bad += pos_bad + rgb_bad;
            f_hb += hb_bad;
        end
        chk({name, " hsync_lines_wrong"}, f_hs_bad, 0);
        chk({name, " de_total"}, f_de, HA * VA);
        chk({name, " vsync_first_line"}, f_vs_first, vs_exp);
        chk({name, " vsync_lines"}, f_vs_lines, 3);
        chk({name, " vsync_partial_lines"}, f_vs_partial, 0);
        chk({name, " frame_start_count"}, f_fs, 1);
        chk({name, " frame_start_at_wrap"}, f_fs_last, 1);
        chk({name, " pos_rgb_blank_errs"}, f_bad, 0);
        chk({name, " hsync_outside_hblank"}, f_hb, 0);
    endtask

    initial begin
        bus.ce_pix = 1'b0;
        bus.hoffs  = '0;
        bus.voffs  = 5'sd2;
        bus.rgb_in = 8'hFF;
        repeat (3) @(negedge clk_sys);
        chk("rst hblank", 32'(bus.hblank), 1);
        chk("rst vblank", 32'(bus.vblank), 1);
        chk("rst hsync_n", 32'(bus.hsync_n), 1);
        chk("rst vsync_n", 32'(bus.vsync_n), 1);
        chk("rst de", 32'(bus.de), 0);
        chk("rst rgb_out", 32'(bus.rgb_out), 0);
        chk("rst frame_start", 32'(bus.frame_start), 0);
        chk("rst hpos", 32'(bus.hpos), 0);
        chk("rst vpos", 32'(bus.vpos), 0);
        reset = 1'b0;

        // hoffs changes mid-frame; only the next frame sees it
        run_frame("f0", 360, VS_NOM, 1, 5);
        run_frame("f1", 370, VS_OFF, 0, -16);
        run_frame("f2", 336, VS_OFF, 0, 15);

        run_line(0);
        chk("f3 hsync_start", hs_first, 390);
        chk("f3 hsync_len", hs_len, 24);
        chk("f3 pos_rgb_errs", pos_bad + rgb_bad, 0);
        chk("f3 hsync_outside_hblank", hb_bad, 0);

        repeat (401) ce_cycle(8'hC3);
        chk("pre_hold hpos", 32'(bus.hpos), 401);
        chk("pre_hold hsync_n", 32'(bus.hsync_n), 0);
        repeat (50) @(negedge clk_sys);
        chk("hold hpos", 32'(bus.hpos), 401);
        chk("hold vpos", 32'(bus.vpos), 1);
        chk("hold hsync_n", 32'(bus.hsync_n), 0);
        chk("hold hblank", 32'(bus.hblank), 1);
        chk("hold vblank", 32'(bus.vblank), 0);
        chk("hold de", 32'(bus.de), 0);
        chk("hold frame_start", 32'(bus.frame_start), 0);

        reset = 1'b1;
        #1;
        chk("midrst hsync_n", 32'(bus.hsync_n), 1);
        chk("midrst hblank", 32'(bus.hblank), 1);
        chk("midrst vblank", 32'(bus.vblank), 1);
        chk("midrst de", 32'(bus.de), 0);
        chk("midrst hpos", 32'(bus.hpos), 0);
        chk("midrst vpos", 32'(bus.vpos), 0);
        @(negedge clk_sys);
        reset = 1'b0;

        // Latched offset is cleared by reset even though hoffs input is still +15
        run_line(0);
        chk("postrst hsync_start", hs_first, 360);
        chk("postrst hsync_len", hs_len, 24);
        chk("postrst de_count", de_cnt, HA);
        chk("postrst pos_rgb_errs", pos_bad + rgb_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
